// File: rtl/deserializer_out.sv
// Receive-side deserializer: finds 9-bit comma alignment on the serial stream,
// verifies lock, then unpacks [comma][d0][d1][d2] frames into a 24-bit payload.
module deserializer_out #(
    parameter logic [7:0]  COMMA       = 8'h3C,
    parameter int unsigned LOCK_COMMAS = 2,
    parameter int unsigned ERR_LIMIT   = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        data_i,
    output logic [23:0] data_o,
    output logic        valid_o,
    output logic        lock_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    localparam logic [2:0] LOCK_N = 3'(LOCK_COMMAS);
    localparam logic [2:0] ERR_N  = 3'(ERR_LIMIT);

    state_t      state, state_n;
    logic [8:0]  win, win_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [2:0]  pos, pos_n;
    logic [2:0]  comma_cnt, comma_cnt_n;
    logic [2:0]  err_cnt, err_cnt_n;
    logic [7:0]  d0, d0_n, d1, d1_n;
    logic [23:0] data_n;
    logic        valid_n, err_n;
    logic        boundary, is_comma, good, bad;
    logic [2:0]  comma_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_HUNT;
            win       <= '0;
            bit_cnt   <= '0;
            pos       <= '0;
            comma_cnt <= '0;
            err_cnt   <= '0;
            d0        <= '0;
            d1        <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_n;
            win       <= win_n;
            bit_cnt   <= bit_cnt_n;
            pos       <= pos_n;
            comma_cnt <= comma_cnt_n;
            err_cnt   <= err_cnt_n;
            d0        <= d0_n;
            d1        <= d1_n;
            data_o    <= data_n;
            valid_o   <= valid_n;
            err_o     <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        win_n       = win;
        bit_cnt_n   = bit_cnt;
        pos_n       = pos;
        comma_cnt_n = comma_cnt;
        err_cnt_n   = err_cnt;
        d0_n        = d0;
        d1_n        = d1;
        data_n      = data_o;
        valid_n     = 1'b0;
        err_n       = 1'b0;
        good        = 1'b0;
        bad         = 1'b0;
        boundary    = 1'b0;
        is_comma    = 1'b0;
        comma_inc   = (comma_cnt == 3'd7) ? comma_cnt : comma_cnt + 3'd1;

        if (en_i) begin
            // Symbol decisions use the window including this cycle's bit.
            win_n     = {win[7:0], data_i};
            boundary  = (bit_cnt == 4'd8);
            bit_cnt_n = boundary ? 4'd0 : bit_cnt + 4'd1;
            is_comma  = (win_n == {1'b1, COMMA});

            case (state)
                ST_HUNT: begin
                    if (is_comma) begin
                        bit_cnt_n   = 4'd0;
                        comma_cnt_n = 3'd1;
                        pos_n       = 3'd1;
                        state_n     = (LOCK_N == 3'd1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt_n = comma_inc;
                            if (comma_inc >= LOCK_N) begin
                                state_n = ST_LOCKED;
                                pos_n   = 3'd1;
                            end
                        end else if (win_n[8]) begin
                            state_n     = ST_HUNT;
                            comma_cnt_n = 3'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        if (is_comma) begin
                            // A comma after d0 or d1 truncates that frame.
                            pos_n = 3'd1;
                            if (pos >= 3'd2) bad = 1'b1;
                            else             good = 1'b1;
                        end else if (!win_n[8]) begin
                            case (pos)
                                3'd1: begin d0_n = win_n[7:0]; pos_n = 3'd2; good = 1'b1; end
                                3'd2: begin d1_n = win_n[7:0]; pos_n = 3'd3; good = 1'b1; end
                                3'd3: begin
                                    data_n  = {win_n[7:0], d1, d0};
                                    valid_n = 1'b1;
                                    pos_n   = 3'd0;
                                    good    = 1'b1;
                                end
                                default: bad = 1'b1;
                            endcase
                        end else begin
                            bad   = 1'b1;
                            pos_n = 3'd0;
                        end

                        if (good) err_cnt_n = 3'd0;
                        if (bad) begin
                            err_n = 1'b1;
                            if (err_cnt + 3'd1 >= ERR_N) begin
                                state_n     = ST_HUNT;
                                err_cnt_n   = 3'd0;
                                comma_cnt_n = 3'd0;
                                pos_n       = 3'd0;
                                bit_cnt_n   = 4'd0;
                            end else begin
                                err_cnt_n = err_cnt + 3'd1;
                            end
                        end
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    assign lock_o = (state == ST_LOCKED);

endmodule

// File: tb/tb_deserializer_out.sv
// Directed bench for deserializer_out: lock, framing, gapped enables,
// truncation, loss of lock, misalignment and asynchronous reset.
module tb_deserializer_out;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        data_i = 1'b0;
    logic [23:0] data_o;
    logic        valid_o, lock_o, err_o;

    int unsigned total = 0;
    int unsigned fails = 0;
    int unsigned vcnt = 0;
    int unsigned ecnt = 0;
    int unsigned v0, e0;

    localparam logic [8:0] K_COMMA = 9'h13C;
    localparam logic [8:0] K_BAD   = 9'h1FF;

    deserializer_out #(.COMMA(8'h3C), .LOCK_COMMAS(2), .ERR_LIMIT(3)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .data_i (data_i),
        .data_o (data_o),
        .valid_o(valid_o),
        .lock_o (lock_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters, sampled mid-cycle after the active edge.
    always @(posedge clk_i) begin
        #2;
        if (valid_o) vcnt++;
        if (err_o)   ecnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gap mode inserts two disabled cycles (with a flipped bit) before each bit.
    task automatic tick_bit(input logic b, input bit gap);
        if (gap) begin
            repeat (2) begin
                @(negedge clk_i);
                en_i   = 1'b0;
                data_i = ~b;
            end
        end
        @(negedge clk_i);
        en_i   = 1'b1;
        data_i = b;
    endtask

    task automatic send(input logic [8:0] s, input bit gap);
        for (int i = 8; i >= 0; i--) tick_bit(s[i], gap);
    endtask

    task automatic idle();
        @(negedge clk_i);
        en_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        en_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #1;
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_lock", 32'(lock_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);

        // Clean stream, then the same stream with gapped enables.
        for (int g = 0; g < 2; g++) begin
            do_reset();
            v0 = vcnt; e0 = ecnt;
            tick_bit(1'b1, g != 0); tick_bit(1'b0, g != 0); tick_bit(1'b1, g != 0);
            send(K_COMMA, g != 0);
            idle();
            chk("lock_after_c1", 32'(lock_o), 32'h0);
            send(K_COMMA, g != 0);
            chk("lock_pre_edge", 32'(lock_o), 32'h0);
            idle();
            chk("lock_after_c2", 32'(lock_o), 32'h1);
            send({1'b0, 8'h11}, g != 0);
            send({1'b0, 8'h22}, g != 0);
            send({1'b0, 8'h33}, g != 0);
            chk("valid_pre_edge", 32'(valid_o), 32'h0);
            idle();
            chk("valid_pulse", 32'(valid_o), 32'h1);
            chk("data_332211", 32'(data_o), 32'h332211);
            idle();
            chk("valid_one_cycle", 32'(valid_o), 32'h0);
            chk("data_hold", 32'(data_o), 32'h332211);
            send(K_COMMA, g != 0);
            idle();
            chk("clean_valid_cnt", vcnt - v0, 32'd1);
            chk("clean_err_cnt", ecnt - e0, 32'd0);
            chk("clean_lock", 32'(lock_o), 32'h1);
        end

        // Truncated frame while locked.
        v0 = vcnt; e0 = ecnt;
        send({1'b0, 8'hAA}, 1'b0);
        send({1'b0, 8'hBB}, 1'b0);
        send(K_COMMA, 1'b0);
        idle();
        chk("trunc_err_pulse", 32'(err_o), 32'h1);
        chk("trunc_no_valid", vcnt - v0, 32'd0);
        idle();
        chk("trunc_err_one", 32'(err_o), 32'h0);
        send({1'b0, 8'h01}, 1'b0);
        send({1'b0, 8'h02}, 1'b0);
        send({1'b0, 8'h03}, 1'b0);
        idle();
        chk("trunc_valid", 32'(valid_o), 32'h1);
        chk("trunc_data", 32'(data_o), 32'h030201);
        chk("trunc_err_cnt", ecnt - e0, 32'd1);
        chk("trunc_lock", 32'(lock_o), 32'h1);

        // Loss of lock after three bad K symbols, then relock.
        e0 = ecnt;
        send(K_BAD, 1'b0);
        send(K_BAD, 1'b0);
        idle();
        chk("lol_still_locked", 32'(lock_o), 32'h1);
        send(K_BAD, 1'b0);
        chk("lol_pre_edge", 32'(lock_o), 32'h1);
        idle();
        chk("lol_dropped", 32'(lock_o), 32'h0);
        chk("lol_third_err", 32'(err_o), 32'h1);
        chk("lol_err_cnt", ecnt - e0, 32'd3);
        send(K_COMMA, 1'b0);
        idle();
        chk("relock_one_comma", 32'(lock_o), 32'h0);
        send(K_COMMA, 1'b0);
        idle();
        chk("relock", 32'(lock_o), 32'h1);
        send({1'b0, 8'h44}, 1'b0);
        send({1'b0, 8'h55}, 1'b0);
        send({1'b0, 8'h66}, 1'b0);
        idle();
        chk("relock_data", 32'(data_o), 32'h665544);

        // Comma offset by 4 bits inside a data stream; data allowed in verify.
        do_reset();
        v0 = vcnt; e0 = ecnt;
        send({1'b0, 8'h55}, 1'b0);
        tick_bit(1'b0, 1'b0); tick_bit(1'b1, 1'b0); tick_bit(1'b0, 1'b0); tick_bit(1'b1, 1'b0);
        send(K_COMMA, 1'b0);
        send({1'b0, 8'h44}, 1'b0);
        idle();
        chk("mis_verify_nolock", 32'(lock_o), 32'h0);
        chk("mis_verify_novalid", vcnt - v0, 32'd0);
        send(K_COMMA, 1'b0);
        idle();
        chk("mis_lock", 32'(lock_o), 32'h1);
        send({1'b0, 8'h5A}, 1'b0);
        send({1'b0, 8'hC3}, 1'b0);
        send({1'b0, 8'h0F}, 1'b0);
        idle();
        chk("mis_data", 32'(data_o), 32'h0FC35A);
        chk("mis_valid_cnt", vcnt - v0, 32'd1);
        chk("mis_err_cnt", ecnt - e0, 32'd0);

        // Asynchronous reset between d1 and d2.
        send(K_COMMA, 1'b0);
        send({1'b0, 8'h77}, 1'b0);
        send({1'b0, 8'h88}, 1'b0);
        @(negedge clk_i);
        en_i   = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("arst_lock", 32'(lock_o), 32'h0);
        chk("arst_data", 32'(data_o), 32'h0);
        chk("arst_valid", 32'(valid_o), 32'h0);
        v0 = vcnt;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        send({1'b0, 8'h99}, 1'b0);
        idle();
        chk("arst_no_valid", vcnt - v0, 32'd0);
        chk("arst_unlocked", 32'(lock_o), 32'h0);
        send(K_COMMA, 1'b0);
        send(K_COMMA, 1'b0);
        send({1'b0, 8'h01}, 1'b0);
        send({1'b0, 8'h02}, 1'b0);
        send({1'b0, 8'h03}, 1'b0);
        idle();
        chk("arst_relock_valid", 32'(valid_o), 32'h1);
        chk("arst_relock_data", 32'(data_o), 32'h030201);
        // Reset coinciding with a valid pulse clears it at once.
        rst_ni = 1'b0;
        #1;
        chk("arst_kills_valid", 32'(valid_o), 32'h0);
        chk("arst_kills_data", 32'(data_o), 32'h0);
        #10;
        rst_ni = 1'b1;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
